// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory path.
// Mask/extension codes match those used by the control pipeline.
package mem_pkg;

    typedef enum logic [1:0] {
        MASK_BYTE = 2'b00,
        MASK_HALF = 2'b01,
        MASK_WORD = 2'b10,
        MASK_ILL  = 2'b11
    } mask_type_t;

    typedef enum logic {
        EXT_SIGN = 1'b0,
        EXT_ZERO = 1'b1
    } ext_type_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        mask_type_t  mask;
        ext_type_t   ext;
    } mem_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering shared by the load and store paths.
// Ports: word/addr/mask/ext/wdata in; extended load data,
// merged store word and misalign flag out.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  mask_type_t  mask,
    input  ext_type_t   ext,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] wword,
    output logic        misalign
);

    logic [7:0]  b_sel;
    logic [15:0] h_sel;
    logic        sx;

    always_comb begin
        b_sel    = word[{addr, 3'b000} +: 8];
        h_sel    = addr[1] ? word[31:16] : word[15:0];
        sx       = (ext == EXT_SIGN);
        rdata    = '0;
        wword    = word;
        misalign = 1'b0;
        unique case (1'b1)
            (mask == MASK_BYTE): begin
                rdata = {{24{sx && b_sel[7]}}, b_sel};
                wword[{addr, 3'b000} +: 8] = wdata[7:0];
            end
            (mask == MASK_HALF): begin
                rdata = {{16{sx && h_sel[15]}}, h_sel};
                if (addr[1])
                    wword[31:16] = wdata[15:0];
                else
                    wword[15:0] = wdata[15:0];
                misalign = addr[0];
            end
            (mask == MASK_WORD): begin
                rdata    = word;
                wword    = wdata;
                misalign = |addr;
            end
            default: begin
                rdata = '0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Variable-latency data-memory responder with lane extension.
// Ports: req handshake (valid/ready, addr, we, wdata, mask, ext),
// rsp handshake (valid/ready, rdata, err), clock, async reset.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_we,
    input  logic [31:0] i_req_wdata,
    input  logic [1:0]  i_req_mask_type,
    input  logic        i_req_ext_type,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    localparam int IDXW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    resp_state_t state_q;
    logic [3:0]  cnt_q;
    mem_req_t    lat_q;
    mem_req_t    cur;

    logic [31:0] mem [DEPTH_WORDS];

    logic [IDXW-1:0] idx;
    logic [29:0]     hi_bits;
    logic            oor;
    logic [31:0]     rd_word;
    logic [31:0]     ld_data;
    logic [31:0]     st_word;
    logic            misalign;
    logic            acc_err;
    logic [31:0]     acc_rdata;
    logic            commit;
    logic            mem_we;

    // With zero wait states the access happens on the accept edge,
    // so the live request is used instead of the latched copy.
    always_comb begin
        cur = lat_q;
        if (state_q == IDLE) begin
            cur.addr  = i_req_addr;
            cur.we    = i_req_we;
            cur.wdata = i_req_wdata;
            cur.mask  = mask_type_t'(i_req_mask_type);
            cur.ext   = ext_type_t'(i_req_ext_type);
        end
    end

    assign idx     = cur.addr[IDXW+1:2];
    assign hi_bits = cur.addr[31:2] >> IDXW;
    assign oor     = |hi_bits;
    assign rd_word = mem[idx];

    mem_lane_align u_align (
        .word     (rd_word),
        .addr     (cur.addr[1:0]),
        .mask     (cur.mask),
        .ext      (cur.ext),
        .wdata    (cur.wdata),
        .rdata    (ld_data),
        .wword    (st_word),
        .misalign (misalign)
    );

    assign acc_err   = misalign || oor || (cur.mask == MASK_ILL);
    assign acc_rdata = (cur.we || acc_err) ? 32'd0 : ld_data;

    always_comb begin
        commit = 1'b0;
        if (state_q == WAIT && cnt_q == 4'd0)
            commit = 1'b1;
        if (WAIT_CYCLES == 0 && state_q == IDLE && i_req_valid)
            commit = 1'b1;
    end

    assign mem_we = commit && cur.we && !acc_err && !i_rst;

    // Array contents survive reset.
    always_ff @(posedge i_clk) begin
        if (mem_we)
            mem[idx] <= st_word;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            lat_q       <= '0;
            o_req_ready <= 1'b1;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= 32'd0;
            o_rsp_err   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_req_valid) begin
                        lat_q       <= cur;
                        o_req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_q     <= RESP;
                            o_rsp_valid <= 1'b1;
                            o_rsp_rdata <= acc_rdata;
                            o_rsp_err   <= acc_err;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= RESP;
                        o_rsp_valid <= 1'b1;
                        o_rsp_rdata <= acc_rdata;
                        o_rsp_err   <= acc_err;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    // Return to IDLE first; no accept in this cycle.
                    if (i_rsp_ready) begin
                        state_q     <= IDLE;
                        o_req_ready <= 1'b1;
                        o_rsp_valid <= 1'b0;
                        o_rsp_rdata <= 32'd0;
                        o_rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    o_req_ready <= 1'b1;
                    o_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
